reorder_buffer_mw: RTL and testbench

Parametrised multi-channel successor to the single-port reorder buffer in the Tomasulo pipeline. It accepts one dispatch per cycle and absorbs CDB_CH completion broadcasts per cycle. It retires up to RETIRE_W ready entries per cycle in program order to the register file. It raises a one-cycle flush with a redirect PC when a mispredicted branch retires.

---
 rtl/reorder_buffer_mw_if.sv | 43 ++++
 rtl/reorder_buffer_mw.sv | 166 ++++++++++++++++
 tb/tb_reorder_buffer_mw.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_mw_if.sv
// rtl/reorder_buffer_mw_if.sv - dispatch/CDB/search/retire bundle for the multi-channel reorder buffer
interface reorder_buffer_mw_if #(
  parameter int ROB_DEPTH = 16,
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int CDB_CH    = 2,
  parameter int RETIRE_W  = 2
);
  localparam int TW = $clog2(ROB_DEPTH);

  logic                       dispatch_valid;
  logic [REG_AW-1:0]          dispatch_dst;
  logic                       dispatch_ready;
  logic [TW-1:0]              assign_tag;
  logic [CDB_CH-1:0]          cdb_valid;
  logic [CDB_CH*TW-1:0]       cdb_tag;
  logic [CDB_CH*XLEN-1:0]     cdb_data;
  logic [CDB_CH-1:0]          cdb_mispredict;
  logic [CDB_CH*XLEN-1:0]     cdb_target_pc;
  logic [2*TW-1:0]            search_tag;
  logic [1:0]                 search_ready;
  logic [2*XLEN-1:0]          search_data;
  logic [RETIRE_W-1:0]        retire_en;
  logic [RETIRE_W*REG_AW-1:0] retire_reg;
  logic [RETIRE_W*XLEN-1:0]   retire_data;
  logic                       flush;
  logic [XLEN-1:0]            flush_pc;
  logic [TW:0]                count;

  modport master (
    output dispatch_valid, dispatch_dst, cdb_valid, cdb_tag, cdb_data,
           cdb_mispredict, cdb_target_pc, search_tag,
    input  dispatch_ready, assign_tag, search_ready, search_data,
           retire_en, retire_reg, retire_data, flush, flush_pc, count
  );

  modport slave (
    input  dispatch_valid, dispatch_dst, cdb_valid, cdb_tag, cdb_data,
           cdb_mispredict, cdb_target_pc, search_tag,
    output dispatch_ready, assign_tag, search_ready, search_data,
           retire_en, retire_reg, retire_data, flush, flush_pc, count
  );
endinterface

// File: rtl/reorder_buffer_mw.sv
// rtl/reorder_buffer_mw.sv - multi-channel reorder buffer, in-order multi-retire with mispredict flush
// Optional ROB_CDB_BYPASS_EN: operand search also sees same-cycle CDB broadcasts.
module reorder_buffer_mw #(
  parameter int ROB_DEPTH = 16,
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int CDB_CH    = 2,
  parameter int RETIRE_W  = 2
) (
  input logic                 clk,
  input logic                 reset,
  reorder_buffer_mw_if.slave  bus
);
  localparam int TW = $clog2(ROB_DEPTH);
  localparam logic [TW:0] ONE  = (TW+1)'(1);
  localparam logic [TW:0] FULL = (TW+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]       r_busy, r_done, r_mispred;
  logic [REG_AW-1:0]          r_dst    [ROB_DEPTH];
  logic [XLEN-1:0]            r_value  [ROB_DEPTH];
  logic [XLEN-1:0]            r_target [ROB_DEPTH];
  logic [TW:0]                r_head, r_tail, r_count;
  logic [RETIRE_W-1:0]        r_retire_en;
  logic [RETIRE_W*REG_AW-1:0] r_retire_reg;
  logic [RETIRE_W*XLEN-1:0]   r_retire_data;
  logic                       r_flush;
  logic [XLEN-1:0]            r_flush_pc;

  logic                       w_ready, w_fire;
  logic [TW-1:0]              w_slot [RETIRE_W];
  logic [TW-1:0]              w_ctag [CDB_CH];
  logic [TW-1:0]              w_stag [2];
  logic [RETIRE_W-1:0]        w_ret;
  logic [TW:0]                w_ret_n, w_head_nxt, w_tail_nxt;
  logic                       w_stop, w_flush;
  logic [XLEN-1:0]            w_flush_pc;
  logic [1:0]                 w_sready;
  logic [2*XLEN-1:0]          w_sdata;

  // Full is judged on the registered count: a same-cycle retire never frees a slot.
  assign w_ready    = (r_count != FULL);
  assign w_fire     = bus.dispatch_valid && w_ready;
  assign w_head_nxt = r_head + w_ret_n;
  assign w_tail_nxt = r_tail + (w_fire ? ONE : '0);

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) w_slot[k] = r_head[TW-1:0] + TW'(k);
    for (int c = 0; c < CDB_CH; c++) w_ctag[c] = bus.cdb_tag[c*TW +: TW];
  end

  // Retire scan from head; stops at the first non-ready entry or after a mispredicted one.
  always_comb begin
    w_ret      = '0;
    w_ret_n    = '0;
    w_stop     = 1'b0;
    w_flush    = 1'b0;
    w_flush_pc = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (!w_stop && r_busy[w_slot[k]] && r_done[w_slot[k]]) begin
        w_ret[k] = 1'b1;
        w_ret_n  = w_ret_n + ONE;
        if (r_mispred[w_slot[k]]) begin
          w_flush    = 1'b1;
          w_flush_pc = r_target[w_slot[k]];
          w_stop     = 1'b1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  always_comb begin
    w_sready = '0;
    w_sdata  = '0;
    for (int i = 0; i < 2; i++) begin
      w_stag[i] = bus.search_tag[i*TW +: TW];
      if (r_busy[w_stag[i]] && r_done[w_stag[i]]) begin
        w_sready[i]               = 1'b1;
        w_sdata[i*XLEN +: XLEN]   = r_value[w_stag[i]];
      end
`ifdef ROB_CDB_BYPASS_EN
      for (int c = CDB_CH-1; c >= 0; c--) begin
        if (bus.cdb_valid[c] && w_ctag[c] == w_stag[i] && r_busy[w_stag[i]]) begin
          w_sready[i]             = 1'b1;
          w_sdata[i*XLEN +: XLEN] = bus.cdb_data[c*XLEN +: XLEN];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy        <= '0;
      r_done        <= '0;
      r_mispred     <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_retire_en   <= '0;
      r_retire_reg  <= '0;
      r_retire_data <= '0;
      r_flush       <= 1'b0;
      r_flush_pc    <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_dst[i]    <= '0;
        r_value[i]  <= '0;
        r_target[i] <= '0;
      end
    end else begin
      for (int k = 0; k < RETIRE_W; k++) begin
        r_retire_en[k]                    <= w_ret[k] && (r_dst[w_slot[k]] != '0);
        r_retire_reg[k*REG_AW +: REG_AW]  <= w_ret[k] ? r_dst[w_slot[k]]   : '0;
        r_retire_data[k*XLEN +: XLEN]     <= w_ret[k] ? r_value[w_slot[k]] : '0;
      end
      r_flush    <= w_flush;
      r_flush_pc <= w_flush ? w_flush_pc : '0;
      if (w_flush) begin
        r_busy    <= '0;
        r_done    <= '0;
        r_mispred <= '0;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
      end else begin
        // Descending channel order so the lowest channel's write lands last and wins.
        for (int c = CDB_CH-1; c >= 0; c--) begin
          if (bus.cdb_valid[c] && r_busy[w_ctag[c]] && !r_done[w_ctag[c]]) begin
            r_done[w_ctag[c]]    <= 1'b1;
            r_value[w_ctag[c]]   <= bus.cdb_data[c*XLEN +: XLEN];
            r_mispred[w_ctag[c]] <= bus.cdb_mispredict[c];
            r_target[w_ctag[c]]  <= bus.cdb_target_pc[c*XLEN +: XLEN];
          end
        end
        for (int k = 0; k < RETIRE_W; k++) begin
          if (w_ret[k]) begin
            r_busy[w_slot[k]] <= 1'b0;
            r_done[w_slot[k]] <= 1'b0;
          end
        end
        if (w_fire) begin
          r_busy[r_tail[TW-1:0]]    <= 1'b1;
          r_done[r_tail[TW-1:0]]    <= 1'b0;
          r_mispred[r_tail[TW-1:0]] <= 1'b0;
          r_dst[r_tail[TW-1:0]]     <= bus.dispatch_dst;
          r_value[r_tail[TW-1:0]]   <= '0;
        end
        r_head  <= w_head_nxt;
        r_tail  <= w_tail_nxt;
        r_count <= w_tail_nxt - w_head_nxt;
      end
    end
  end

  assign bus.dispatch_ready = w_ready;
  assign bus.assign_tag     = r_tail[TW-1:0];
  assign bus.search_ready   = w_sready;
  assign bus.search_data    = w_sdata;
  assign bus.retire_en      = r_retire_en;
  assign bus.retire_reg     = r_retire_reg;
  assign bus.retire_data    = r_retire_data;
  assign bus.flush          = r_flush;
  assign bus.flush_pc       = r_flush_pc;
  assign bus.count          = r_count;
endmodule

// File: tb/tb_reorder_buffer_mw.sv
// tb/tb_reorder_buffer_mw.sv - randomized and directed bench for reorder_buffer_mw against a queue model
module tb_reorder_buffer_mw;
  localparam int D    = 16;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int CH   = 2;
  localparam int RW   = 2;
  localparam int TW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_mw_if #(.ROB_DEPTH(D), .XLEN(XLEN), .REG_AW(RAW), .CDB_CH(CH), .RETIRE_W(RW)) bus ();
  reorder_buffer_mw #(.ROB_DEPTH(D), .XLEN(XLEN), .REG_AW(RAW), .CDB_CH(CH), .RETIRE_W(RW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             tag;
    logic [RAW-1:0] dst;
    bit             done;
    bit             mp;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] tgt;
  } ent_t;

  ent_t            q[$];
  int              m_tail;
  logic [RW-1:0]   e_ret, e_en;
  logic [RAW-1:0]  e_reg  [RW];
  logic [XLEN-1:0] e_data [RW];
  logic            e_flush;
  logic [XLEN-1:0] e_pc;
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.dispatch_valid = 1'b0;
    bus.dispatch_dst   = '0;
    bus.cdb_valid      = '0;
    bus.cdb_tag        = '0;
    bus.cdb_data       = '0;
    bus.cdb_mispredict = '0;
    bus.cdb_target_pc  = '0;
    bus.search_tag     = 8'($urandom);
  endtask

  task automatic set_cdb(input int c, input int tag, input logic [XLEN-1:0] d,
                         input bit mp, input logic [XLEN-1:0] t);
    bus.cdb_valid[c]               = 1'b1;
    bus.cdb_tag[c*TW +: TW]        = TW'(tag);
    bus.cdb_data[c*XLEN +: XLEN]   = d;
    bus.cdb_mispredict[c]          = mp;
    bus.cdb_target_pc[c*XLEN +: XLEN] = t;
  endtask

  task automatic dispatch(input logic [RAW-1:0] dst);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_dst   = dst;
  endtask

  // {ready, data} expected for a lookup of tag st given the model contents and current CDB inputs
  function automatic logic [XLEN:0] m_search(input int st);
    logic [XLEN:0] r = '0;
    int hit = -1;
    foreach (q[i]) if (q[i].tag == st) hit = i;
    if (hit >= 0 && q[hit].done) r = {1'b1, q[hit].val};
`ifdef ROB_CDB_BYPASS_EN
    if (hit >= 0) begin
      for (int c = 0; c < CH; c++) begin
        if (bus.cdb_valid[c] && int'(bus.cdb_tag[c*TW +: TW]) == st) begin
          r = {1'b1, bus.cdb_data[c*XLEN +: XLEN]};
          break;
        end
      end
    end
`endif
    return r;
  endfunction

  task automatic model_edge();
    int sz0  = q.size();
    int nret = 0;
    e_ret = '0; e_en = '0; e_flush = 1'b0; e_pc = '0;
    for (int k = 0; k < RW; k++) begin e_reg[k] = '0; e_data[k] = '0; end
    for (int k = 0; k < RW && k < sz0; k++) begin
      if (!q[k].done) break;
      e_ret[k] = 1'b1; e_en[k] = (q[k].dst != 0);
      e_reg[k] = q[k].dst; e_data[k] = q[k].val;
      nret++;
      if (q[k].mp) begin e_flush = 1'b1; e_pc = q[k].tgt; break; end
    end
    if (e_flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    for (int c = 0; c < CH; c++) begin
      if (bus.cdb_valid[c]) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(bus.cdb_tag[c*TW +: TW]) && !q[i].done) begin
            q[i].done = 1'b1;
            q[i].val  = bus.cdb_data[c*XLEN +: XLEN];
            q[i].mp   = bus.cdb_mispredict[c];
            q[i].tgt  = bus.cdb_target_pc[c*XLEN +: XLEN];
          end
        end
      end
    end
    repeat (nret) void'(q.pop_front());
    if (bus.dispatch_valid && sz0 < D) begin
      q.push_back('{tag: m_tail, dst: bus.dispatch_dst, done: 1'b0, mp: 1'b0, val: '0, tgt: '0});
      m_tail = (m_tail + 1) % D;
    end
  endtask

  task automatic check_outputs();
    check("count", 64'(bus.count), 64'(q.size()));
    check("dispatch_ready", 64'(bus.dispatch_ready), 64'(q.size() < D));
    check("assign_tag", 64'(bus.assign_tag), 64'(m_tail));
    check("flush", 64'(bus.flush), 64'(e_flush));
    check("flush_pc", 64'(bus.flush_pc), 64'(e_pc));
    check("retire_en", 64'(bus.retire_en), 64'(e_en));
    for (int k = 0; k < RW; k++) begin
      if (e_ret[k]) begin
        check($sformatf("retire_reg%0d", k), 64'(bus.retire_reg[k*RAW +: RAW]), 64'(e_reg[k]));
        check($sformatf("retire_data%0d", k), 64'(bus.retire_data[k*XLEN +: XLEN]), 64'(e_data[k]));
      end
    end
  endtask

  task automatic step();
    logic [XLEN:0] s;
    #1;
    for (int i = 0; i < 2; i++) begin
      s = m_search(int'(bus.search_tag[i*TW +: TW]));
      check($sformatf("search_ready%0d", i), 64'(bus.search_ready[i]), 64'(s[XLEN]));
      if (s[XLEN]) check($sformatf("search_data%0d", i), 64'(bus.search_data[i*XLEN +: XLEN]), 64'(s[XLEN-1:0]));
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    clr();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_ready", 64'(bus.dispatch_ready), 64'd1);
    check("rst_retire_en", 64'(bus.retire_en), 64'd0);
    check("rst_flush", 64'(bus.flush), 64'd0);
    q.delete();
    m_tail = 0;
    e_ret = '0; e_en = '0; e_flush = 1'b0; e_pc = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_assign_tag", 64'(bus.assign_tag), 64'd0);
  endtask

  initial begin
    clr();
    do_reset();

    // Reset in the middle of operation
    repeat (5) begin dispatch(RAW'($urandom_range(1, 31))); step(); end
    check("pre_rst_count", 64'(bus.count), 64'd5);
    do_reset();

    // Fill to full, then a rejected 17th dispatch
    for (int i = 1; i <= 16; i++) begin dispatch(RAW'(i)); step(); end
    check("full_count", 64'(bus.count), 64'd16);
    check("full_ready", 64'(bus.dispatch_ready), 64'd0);
    dispatch(RAW'(17));
    step();
    check("full_tail_hold", 64'(bus.assign_tag), 64'd0);
    check("full_count_hold", 64'(bus.count), 64'd16);
    do_reset();

    // Two retirements in one cycle, a third one cycle later
    dispatch(5'd3); step();
    dispatch(5'd4); step();
    dispatch(5'd5); step();
    set_cdb(0, 0, 32'hAAAA_0001, 1'b0, '0);
    set_cdb(1, 1, 32'hBBBB_0002, 1'b0, '0);
    step();
    check("mr_no_early_retire", 64'(bus.retire_en), 64'd0);
    set_cdb(0, 2, 32'hCCCC_0003, 1'b0, '0);
    step();
    check("mr_slot0_reg", 64'(bus.retire_reg[0 +: RAW]), 64'd3);
    check("mr_slot0_data", 64'(bus.retire_data[0 +: XLEN]), 64'hAAAA_0001);
    check("mr_slot1_reg", 64'(bus.retire_reg[RAW +: RAW]), 64'd4);
    check("mr_slot1_data", 64'(bus.retire_data[XLEN +: XLEN]), 64'hBBBB_0002);
    check("mr_count1", 64'(bus.count), 64'd1);
    step();
    check("mr_slot0_reg_b", 64'(bus.retire_reg[0 +: RAW]), 64'd5);
    check("mr_count0", 64'(bus.count), 64'd0);
    do_reset();

    // Out-of-order completion
    dispatch(5'd7); step();
    dispatch(5'd8); step();
    set_cdb(0, 1, 32'h0000_1111, 1'b0, '0); step();
    step();
    check("ooo_hold", 64'(bus.retire_en), 64'd0);
    set_cdb(1, 0, 32'h0000_0000, 1'b0, '0); step();
    step();
    check("ooo_both", 64'(bus.retire_en), 64'b11);
    check("ooo_oldest_slot0", 64'(bus.retire_reg[0 +: RAW]), 64'd7);
    do_reset();

    // Mispredicted branch retires with a concurrent dispatch
    for (int i = 1; i <= 5; i++) begin dispatch(RAW'(i)); step(); end
    set_cdb(0, 0, 32'h0000_0050, 1'b0, '0);
    set_cdb(1, 1, 32'h0000_0060, 1'b1, 32'h0000_0400);
    step();
    dispatch(5'd9);
    step();
    check("mp_flush", 64'(bus.flush), 64'd1);
    check("mp_flush_pc", 64'(bus.flush_pc), 64'h400);
    check("mp_count", 64'(bus.count), 64'd0);
    check("mp_retire_en", 64'(bus.retire_en), 64'b11);
    check("mp_dispatch_lost", 64'(bus.assign_tag), 64'd0);
    step();
    check("mp_flush_pulse", 64'(bus.flush), 64'd0);
    do_reset();

    // Two channels carrying the same tag
    for (int i = 1; i <= 3; i++) begin dispatch(RAW'(i)); step(); end
    set_cdb(0, 2, 32'h0000_0011, 1'b0, '0);
    set_cdb(1, 2, 32'h0000_0022, 1'b0, '0);
    bus.search_tag = {4'd2, 4'd2};
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check("col_byp_ready", 64'(bus.search_ready[0]), 64'd1);
    check("col_byp_data", 64'(bus.search_data[0 +: XLEN]), 64'h11);
`else
    check("col_nobyp_ready", 64'(bus.search_ready[0]), 64'd0);
`endif
    step();
    bus.search_tag = {4'd2, 4'd2};
    #1;
    check("col_stored_ready", 64'(bus.search_ready[1]), 64'd1);
    check("col_stored_data", 64'(bus.search_data[XLEN +: XLEN]), 64'h11);
    step();
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) != 0) dispatch(RAW'($urandom));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 1) != 0) begin
          int t;
          if (q.size() > 0 && $urandom_range(0, 3) != 0) t = q[$urandom_range(0, q.size()-1)].tag;
          else t = int'($urandom_range(0, D-1));
          set_cdb(c, t, $urandom, ($urandom_range(0, 15) == 0), $urandom);
        end
      end
      if ($urandom_range(0, 7) == 0 && bus.cdb_valid[0]) begin
        bus.cdb_valid[1]       = 1'b1;
        bus.cdb_tag[TW +: TW]  = bus.cdb_tag[0 +: TW];
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
